// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Holds a small digit store and time-multiplexes it onto a shared active-low
//   segment bus with an active-low digit select. Each digit slot starts with a
//   blanking gap (everything dark) to suppress ghosting while the select moves.
//   A single-cycle frame_tick marks the start of every scan frame.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   wr_en      : write strobe for one digit entry
//   wr_addr    : digit index; indices >= NUM_DIGITS are ignored
//   wr_data    : hex nibble to display
//   wr_dp      : decimal point on (1)
//   wr_blank   : digit dark (1)
//   clear      : blank every digit; wins over a same-cycle write
//   seg        : active-low {dp,g,f,e,d,c,b,a}
//   sel_n      : active-low digit select, at most one bit low
//   frame_tick : one-cycle pulse at the start of each frame
module sevenseg_scan_driver #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 6,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic       clear,
  output logic [7:0] seg,
  output logic [5:0] sel_n,
  output logic       frame_tick
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(DIV - 1);
  localparam logic [PC_W-1:0] BLANK_END = PC_W'(BLANK_CYCLES);
  localparam logic [2:0]      IDX_LAST  = 3'(NUM_DIGITS - 1);

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] nib;
  } entry_t;

  localparam entry_t ENTRY_RST = '{blank: 1'b1, dp: 1'b0, nib: 4'h0};

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PC_W-1:0]              pc_q, pc_d;
  logic [2:0]                   idx_q, idx_d;
  entry_t [NUM_DIGITS-1:0]      store_q, store_d;
  logic [7:0]                   seg_q, seg_d;
  logic [5:0]                   sel_q, sel_d;
  logic                         wrap_q, wrap_d;
  logic                         tick_q;

  always_comb begin
    // Slot prescaler and digit index.
    pc_d   = pc_q + 1'b1;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (pc_q == PC_LAST) begin
      pc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    // Digit store update; out-of-range addresses match no entry and fall away.
    store_d = store_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) store_d[i].blank = 1'b1;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == 3'(i)) store_d[i] = '{blank: wr_blank, dp: wr_dp, nib: wr_data};
      end
    end

    // Output decode from the current (pc, idx); registered below for a 1-clk lag.
    sel_d = 6'h3F;
    seg_d = 8'hFF;
    if (pc_q >= BLANK_END) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == 3'(i)) begin
          sel_d[i] = 1'b0;
          if (!store_q[i].blank) seg_d = {~store_q[i].dp, hex7(store_q[i].nib)};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      idx_q   <= '0;
      store_q <= {NUM_DIGITS{ENTRY_RST}};
      seg_q   <= 8'hFF;
      sel_q   <= 6'h3F;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
      // The wrap is seen one edge after idx returns to 0, so the tick lines up
      // with the first registered output of the new frame.
      tick_q  <= wrap_q;
    end
  end

  assign seg        = seg_q;
  assign sel_n      = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with a small clock so a slot is 10 clocks,
// 2 of them blank, and a frame is 60 clocks. A behavioural model tracks the
// number of edges since reset release and derives slot/phase arithmetically.
module tb_sevenseg_scan_driver;

  localparam int CLK_HZ     = 1000;
  localparam int SCAN_HZ    = 100;
  localparam int DIV        = CLK_HZ / SCAN_HZ;
  localparam int NUM_DIGITS = 6;
  localparam int BLANK      = 2;
  localparam int FRAME      = NUM_DIGITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] seg;
  logic [5:0] sel_n;
  logic       frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;   // edges since reset release

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model digit store and the snapshot taken before each edge's update.
  logic       m_blank [NUM_DIGITS];
  logic       m_dp    [NUM_DIGITS];
  logic [3:0] m_nib   [NUM_DIGITS];
  logic       s_blank [NUM_DIGITS];
  logic       s_dp    [NUM_DIGITS];
  logic [3:0] s_nib   [NUM_DIGITS];

  int         c, ph, di, a;
  logic [7:0] e_seg;
  logic [5:0] e_sel;
  logic       e_tick;

  sevenseg_scan_driver #(
    .CLK_HZ      (CLK_HZ),
    .SCAN_HZ     (SCAN_HZ),
    .NUM_DIGITS  (NUM_DIGITS),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .clear     (clear),
    .seg       (seg),
    .sel_n     (sel_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Model and per-cycle compare.
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        m_blank[i] = 1'b1;
        m_dp[i]    = 1'b0;
        m_nib[i]   = 4'h0;
      end
      #1;
      check("cyc_rst_seg",  int'(seg),        'hFF);
      check("cyc_rst_sel",  int'(sel_n),      'h3F);
      check("cyc_rst_tick", int'(frame_tick), 0);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        s_blank[i] = m_blank[i];
        s_dp[i]    = m_dp[i];
        s_nib[i]   = m_nib[i];
      end
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) m_blank[i] = 1'b1;
      end else if (wr_en) begin
        a = int'(wr_addr);
        if (a < NUM_DIGITS) begin
          m_blank[a] = wr_blank;
          m_dp[a]    = wr_dp;
          m_nib[a]   = wr_data;
        end
      end
      k = k + 1;
      c  = k - 1;
      ph = c % DIV;
      di = (c / DIV) % NUM_DIGITS;
      e_sel = 6'h3F;
      e_seg = 8'hFF;
      if (ph >= BLANK) begin
        e_sel[di] = 1'b0;
        if (!s_blank[di]) e_seg = {~s_dp[di], hex_tab[s_nib[di]]};
      end
      e_tick = (c > 0) && (c % FRAME == 0);
      #1;
      check("cyc_seg",  int'(seg),        int'(e_seg));
      check("cyc_sel",  int'(sel_n),      int'(e_sel));
      check("cyc_tick", int'(frame_tick), int'(e_tick));
    end
  end

  task automatic goto_k(input int t);
    int n;
    n = 0;
    while (k != t) begin
      @(posedge clk);
      #2;
      n++;
      if (n > 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL goto_k: actual k=%0d required %0d", k, t);
        return;
      end
    end
  endtask

  task automatic wr(input int addr, input logic [3:0] d, input logic dp, input logic bl);
    wr_en    = 1'b1;
    wr_addr  = 3'(addr);
    wr_data  = d;
    wr_dp    = dp;
    wr_blank = bl;
    @(posedge clk);
    #2;
    wr_en    = 1'b0;
  endtask

  logic [3:0] t2_nib [6] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hF};
  logic [7:0] t2_seg [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h88, 8'h83, 8'h8E};
  logic [5:0] t2_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  initial begin
    // T1: reset hold and release timing.
    repeat (3) @(posedge clk);
    #2;
    check("t1_rst_seg",  int'(seg),        'hFF);
    check("t1_rst_sel",  int'(sel_n),      'h3F);
    check("t1_rst_tick", int'(frame_tick), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2; check("t1_e1_sel", int'(sel_n), 'h3F);
    @(posedge clk); #2; check("t1_e2_sel", int'(sel_n), 'h3F);
    @(posedge clk); #2; check("t1_e3_sel", int'(sel_n), 'h3E);
    check("t1_e3_seg", int'(seg), 'hFF);

    // T2: load the store.
    for (int d = 0; d < 6; d++) wr(d, t2_nib[d], 1'b0, 1'b0);

    // T3: frame tick placement.
    goto_k(60);  check("t3_tick_before", int'(frame_tick), 0);
    goto_k(61);  check("t3_tick",        int'(frame_tick), 1);
    goto_k(62);  check("t3_tick_after",  int'(frame_tick), 0);

    // T2: decode in the second frame, mid-SHOW of each slot.
    for (int d = 0; d < 6; d++) begin
      goto_k(66 + 10 * d);
      check("t2_seg", int'(seg),   int'(t2_seg[d]));
      check("t2_sel", int'(sel_n), int'(t2_sel[d]));
    end
    goto_k(121); check("t3_tick2", int'(frame_tick), 1);

    // T4: decimal point, then clear beating a same-cycle write.
    goto_k(126);
    wr(2, 4'h8, 1'b1, 1'b0);
    goto_k(146); check("t4_dp_seg", int'(seg), 'h00);
    check("t4_dp_sel", int'(sel_n), 'h3B);
    goto_k(150);
    clear = 1'b1;
    wr(3, 4'h5, 1'b0, 1'b0);
    clear = 1'b0;
    goto_k(186); check("t4_clr_d0_seg", int'(seg), 'hFF);
    check("t4_clr_d0_sel", int'(sel_n), 'h3E);
    goto_k(216); check("t4_clr_d3_seg", int'(seg), 'hFF);
    check("t4_clr_d3_sel", int'(sel_n), 'h37);

    // T5: out-of-range addresses must not touch the store.
    goto_k(220);
    wr(0, 4'h5, 1'b0, 1'b0);
    wr(4, 4'h7, 1'b0, 1'b0);
    wr(6, 4'h0, 1'b0, 1'b0);
    wr(7, 4'h0, 1'b0, 1'b0);
    goto_k(246); check("t5_d0_seg", int'(seg), 'h92);
    goto_k(256); check("t5_d1_seg", int'(seg), 'hFF);
    goto_k(266); check("t5_d2_seg", int'(seg), 'hFF);

    // T6: asynchronous reset in the middle of digit 4's SHOW phase.
    goto_k(286); check("t6_pre_seg", int'(seg), 'hF8);
    check("t6_pre_sel", int'(sel_n), 'h2F);
    #1 rst = 1'b1;
    #1;
    check("t6_async_seg",  int'(seg),        'hFF);
    check("t6_async_sel",  int'(sel_n),      'h3F);
    check("t6_async_tick", int'(frame_tick), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2; check("t6_e1_sel", int'(sel_n), 'h3F);
    @(posedge clk); #2; check("t6_e2_sel", int'(sel_n), 'h3F);
    @(posedge clk); #2; check("t6_e3_sel", int'(sel_n), 'h3E);
    check("t6_store_blank", int'(seg), 'hFF);
    goto_k(61);  check("t6_tick", int'(frame_tick), 1);
    goto_k(70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
